// File: rtl/cic3_row_pkg.sv
// Shared constants and types for the CIC3 row readout scheduler.
package cic3_row_pkg;

    localparam int NUM_CH = 12;
    localparam int DATA_W = 25;
    localparam int CH_W   = 4;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

    typedef logic [DATA_W-1:0] cic_word_t;

endpackage

// File: rtl/cic3_lsb_pick.sv
// Lowest-set-bit picker over a channel mask, with empty and single-bit flags.
module cic3_lsb_pick
    import cic3_row_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    output logic [CH_W-1:0]   idx_o,
    output logic              none_o,
    output logic              onehot_o
);

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx_o = mask_i[k] ? CH_W'(k) : idx_o;
        end
        none_o   = (mask_i == '0);
        onehot_o = !none_o && ((mask_i & (mask_i - NUM_CH'(1))) == '0);
    end

endmodule

// File: rtl/cic3_row_readout_sched.sv
// Snapshots a row of CIC3 outputs on each tick and streams the enabled channels
// in ascending order over one valid/ready port, counting ticks lost to backpressure.
module cic3_row_readout_sched
    import cic3_row_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] filt_data,
    input  logic                     sample_tick,
    input  logic [NUM_CH-1:0]        chan_en,
    input  logic                     out_ready,
    input  logic                     overrun_clr,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_chan,
    output logic [CNT_W-1:0]         out_frame,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overrun,
    output logic [CNT_W-1:0]         overrun_cnt
);

    sched_state_t              state_q, state_d;
    logic [NUM_CH*DATA_W-1:0]  snap_q, snap_d;
    logic [NUM_CH-1:0]         pend_q, pend_d;
    logic [CNT_W-1:0]          frame_cnt_q, frame_cnt_d;
    logic                      out_valid_q, out_valid_d;
    cic_word_t                 out_data_q, out_data_d;
    logic [CH_W-1:0]           out_chan_q, out_chan_d;
    logic [CNT_W-1:0]          out_frame_q, out_frame_d;
    logic                      out_last_q, out_last_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;
    logic [CNT_W-1:0]          overrun_cnt_q, overrun_cnt_d;

    logic                      hs_s, final_hs_s, accept_s, drop_s;
    logic [CH_W-1:0]           pick_idx_s;
    logic                      pick_none_s, pick_onehot_s;

    // Frame control: handshake retires the lowest pending bit, accepted tick reloads.
    always_comb begin
        hs_s        = out_valid_q & out_ready;
        final_hs_s  = hs_s & out_last_q;
        accept_s    = sample_tick & ((state_q == IDLE) | final_hs_s);
        drop_s      = sample_tick & (state_q == SEND) & ~final_hs_s;
        snap_d      = snap_q;
        frame_cnt_d = frame_cnt_q;
        out_frame_d = out_frame_q;
        if (hs_s) begin
            pend_d = pend_q & (pend_q - NUM_CH'(1));
        end else begin
            pend_d = pend_q;
        end
        if (accept_s) begin
            snap_d      = filt_data;
            pend_d      = chan_en;
            out_frame_d = frame_cnt_q;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        state_d = (pend_d != '0) ? SEND : IDLE;
    end

    cic3_lsb_pick u_pick (
        .mask_i   (pend_d),
        .idx_o    (pick_idx_s),
        .none_o   (pick_none_s),
        .onehot_o (pick_onehot_s)
    );

    // Next beat presentation, derived from the post-update pending mask.
    always_comb begin
        out_valid_d = ~pick_none_s;
        out_chan_d  = pick_idx_s;
        out_last_d  = pick_onehot_s;
        busy_d      = (state_d == SEND);
        out_data_d  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            out_data_d = (pick_idx_s == CH_W'(k)) ? snap_d[k*DATA_W +: DATA_W] : out_data_d;
        end
    end

    // Sticky overrun flag and saturating drop counter; a drop beats a same-cycle clear.
    always_comb begin
        if (overrun_clr) begin
            overrun_d     = drop_s;
            overrun_cnt_d = drop_s ? CNT_W'(1) : CNT_W'(0);
        end else if (drop_s) begin
            overrun_d     = 1'b1;
            overrun_cnt_d = (overrun_cnt_q == {CNT_W{1'b1}}) ? overrun_cnt_q
                                                              : overrun_cnt_q + CNT_W'(1);
        end else begin
            overrun_d     = overrun_q;
            overrun_cnt_d = overrun_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            snap_q        <= '0;
            pend_q        <= '0;
            frame_cnt_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_chan_q    <= '0;
            out_frame_q   <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            pend_q        <= pend_d;
            frame_cnt_q   <= frame_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_chan_q    <= out_chan_d;
            out_frame_q   <= out_frame_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_chan    = out_chan_q;
    assign out_frame   = out_frame_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_cic3_row_readout_sched.sv
// Directed self-checking bench for cic3_row_readout_sched.
module tb_cic3_row_readout_sched;
    import cic3_row_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] filt_data;
    logic                     sample_tick;
    logic [NUM_CH-1:0]        chan_en;
    logic                     out_ready;
    logic                     overrun_clr;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_chan;
    logic [CNT_W-1:0]         out_frame;
    logic                     out_last;
    logic                     busy;
    logic                     overrun;
    logic [CNT_W-1:0]         overrun_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    cic3_row_readout_sched dut (
        .clk         (clk),
        .reset       (reset),
        .filt_data   (filt_data),
        .sample_tick (sample_tick),
        .chan_en     (chan_en),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_frame   (out_frame),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_ramp(input int base);
        for (int k = 0; k < NUM_CH; k++) filt_data[k*DATA_W +: DATA_W] = DATA_W'(base + k);
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_tick = 1'b0; chan_en = '0; out_ready = 1'b0;
        overrun_clr = 1'b0; filt_data = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, out_last, busy, overrun} !== 4'b0000 || out_data !== '0 ||
            out_chan !== '0 || out_frame !== '0 || overrun_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%0b l=%0b b=%0b o=%0b d=%0h c=%0d f=%0d oc=%0d, want all 0",
                     out_valid, out_last, busy, overrun, out_data, out_chan, out_frame, overrun_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // All 12 channels, ready held high: one beat per cycle starting the cycle after the tick.
    task automatic test_full_frame();
        set_ramp(1); chan_en = 12'hFFF; out_ready = 1'b1;
        sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_chan !== CH_W'(i) || out_data !== DATA_W'(i + 1) ||
                out_frame !== 8'd0 || out_last !== (i == 11) || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_beat%0d: got v=%0b c=%0d d=%0d f=%0d l=%0b b=%0b, want v=1 c=%0d d=%0d f=0 l=%0b b=1",
                         i, out_valid, out_chan, out_data, out_frame, out_last, busy, i, i + 1, i == 11);
            end
            @(negedge clk);
        end
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_end: got v=%0b b=%0b, want 0 0", out_valid, busy);
        end
    endtask

    // Sparse mask with alternating stall cycles; outputs must hold while stalled.
    task automatic test_sparse_stall();
        int ch[3] = '{0, 5, 11};
        set_ramp(100); chan_en = 12'h821;
        sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
        chan_en = 12'h000;
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 2; s++) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_chan !== CH_W'(ch[b]) || out_data !== DATA_W'(100 + ch[b]) ||
                    out_frame !== 8'd1 || out_last !== (b == 2) || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL sparse_beat%0d_%0d: got v=%0b c=%0d d=%0d f=%0d l=%0b b=%0b, want v=1 c=%0d d=%0d f=1 l=%0b b=1",
                             b, s, out_valid, out_chan, out_data, out_frame, out_last, busy,
                             ch[b], 100 + ch[b], b == 2);
                end
                out_ready = (s == 1);
                @(negedge clk);
            end
        end
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL sparse_end: got v=%0b b=%0b, want 0 0", out_valid, busy);
        end
    endtask

    // Tick landing on beat 4 is dropped and counted; the frame runs on untouched.
    task automatic test_overrun();
        set_ramp(1); chan_en = 12'hFFF; out_ready = 1'b1;
        sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_chan !== CH_W'(i) || out_data !== DATA_W'(i + 1) ||
                out_frame !== 8'd2 || out_last !== (i == 11)) begin
                tests_failed++;
                $display("FAIL overrun_beat%0d: got v=%0b c=%0d d=%0d f=%0d l=%0b, want v=1 c=%0d d=%0d f=2 l=%0b",
                         i, out_valid, out_chan, out_data, out_frame, out_last, i, i + 1, i == 11);
            end
            if (i == 4) set_ramp(500);
            sample_tick = (i == 4);
            @(negedge clk);
        end
        tests_run++;
        if (out_valid !== 1'b0 || overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL overrun_flag: got v=%0b o=%0b oc=%0d, want v=0 o=1 oc=1", out_valid, overrun, overrun_cnt);
        end
        set_ramp(1);
    endtask

    // Tick on the final handshake chains straight into the next frame without a drop.
    task automatic test_back_to_back();
        chan_en = 12'hFFF; out_ready = 1'b1;
        sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_chan !== CH_W'(i) || out_frame !== 8'd3) begin
                tests_failed++;
                $display("FAIL b2b_beat%0d: got v=%0b c=%0d f=%0d, want v=1 c=%0d f=3", i, out_valid, out_chan, out_frame, i);
            end
            if (i == 11) begin
                set_ramp(200); chan_en = 12'h009; sample_tick = 1'b1;
            end
            @(negedge clk);
        end
        sample_tick = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_chan !== 4'd0 || out_data !== 25'd200 || out_frame !== 8'd4 ||
            out_last !== 1'b0 || overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL b2b_first: got v=%0b c=%0d d=%0d f=%0d l=%0b o=%0b oc=%0d, want v=1 c=0 d=200 f=4 l=0 o=1 oc=1",
                     out_valid, out_chan, out_data, out_frame, out_last, overrun, overrun_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_chan !== 4'd3 || out_data !== 25'd203 || out_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_last: got v=%0b c=%0d d=%0d l=%0b, want v=1 c=3 d=203 l=1", out_valid, out_chan, out_data, out_last);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: got v=%0b b=%0b, want 0 0", out_valid, busy);
        end
    endtask

    // Empty mask still consumes a frame id but emits nothing.
    task automatic test_empty_mask();
        overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL clear: got o=%0b oc=%0d, want 0 0", overrun, overrun_cnt);
        end
        chan_en = 12'h000;
        sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || out_frame !== 8'd5) begin
                tests_failed++;
                $display("FAIL empty_%0d: got v=%0b b=%0b f=%0d, want v=0 b=0 f=5", i, out_valid, busy, out_frame);
            end
            @(negedge clk);
        end
        chan_en = 12'h001;
        sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_chan !== 4'd0 || out_data !== 25'd200 || out_frame !== 8'd6 || out_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_empty: got v=%0b c=%0d d=%0d f=%0d l=%0b, want v=1 c=0 d=200 f=6 l=1",
                     out_valid, out_chan, out_data, out_frame, out_last);
        end
        @(negedge clk);
    endtask

    // Mid-frame reset, then drop-counter saturation, clear, and clear-vs-drop priority.
    task automatic test_reset_midframe_and_saturation();
        set_ramp(1); chan_en = 12'hFFF; out_ready = 1'b1;
        sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (out_chan !== 4'd6 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_beat6: got v=%0b c=%0d, want v=1 c=6", out_valid, out_chan);
        end
        reset = 1'b1; @(negedge clk);
        tests_run++;
        if ({out_valid, out_last, busy, overrun} !== 4'b0000 || out_data !== '0 ||
            out_chan !== '0 || out_frame !== '0 || overrun_cnt !== '0) begin
            tests_failed++;
            $display("FAIL midframe_reset: got v=%0b l=%0b b=%0b o=%0b d=%0h c=%0d f=%0d oc=%0d, want all 0",
                     out_valid, out_last, busy, overrun, out_data, out_chan, out_frame, overrun_cnt);
        end
        reset = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got v=%0b b=%0b, want 0 0", out_valid, busy);
        end
        sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
        for (int n = 0; n < 300; n++) begin
            sample_tick = 1'b1; @(negedge clk);
            sample_tick = 1'b0; @(negedge clk);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_chan !== 4'd0 || out_data !== 25'd1 || out_frame !== 8'd0 ||
            overrun !== 1'b1 || overrun_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL saturate: got v=%0b c=%0d d=%0d f=%0d o=%0b oc=%0d, want v=1 c=0 d=1 f=0 o=1 oc=255",
                     out_valid, out_chan, out_data, out_frame, overrun, overrun_cnt);
        end
        overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL sat_clear: got o=%0b oc=%0d, want 0 0", overrun, overrun_cnt);
        end
        overrun_clr = 1'b1; sample_tick = 1'b1; @(negedge clk);
        overrun_clr = 1'b0; sample_tick = 1'b0;
        tests_run++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL clear_vs_drop: got o=%0b oc=%0d, want 1 1", overrun, overrun_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_sparse_stall();
        test_overrun();
        test_back_to_back();
        test_empty_mask();
        test_reset_midframe_and_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
